// File: rtl/core_scheduler.sv
// Per-core control FSM: sequences a thread block through FETCH..UPDATE, owns the shared PC.
// Optional macro DIVERGE_CHECK_EN adds a sticky flag for lanes whose next PC disagrees.
module core_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_WIDTH          = 8,
    parameter int RETIRE_WIDTH      = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]    thread_count,
    input  logic [2:0]                            fetcher_state,
    input  logic [2*THREADS_PER_BLOCK-1:0]        lsu_state,
    input  logic                                  decoded_ret,
    input  logic [PC_WIDTH*THREADS_PER_BLOCK-1:0] next_pc,
    output logic [2:0]                            core_state,
    output logic [PC_WIDTH-1:0]                   current_pc,
    output logic                                  done,
    output logic [RETIRE_WIDTH-1:0]               retired,
    output logic                                  diverged
);
    localparam int TC_W  = $clog2(THREADS_PER_BLOCK) + 1;
    localparam int IDX_W = (THREADS_PER_BLOCK > 1) ? $clog2(THREADS_PER_BLOCK) : 1;
    localparam logic [2:0] FETCHER_FETCHED = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } state_t;

    state_t                   state_reg, state_next;
    logic [PC_WIDTH-1:0]      pc_reg, pc_next;
    logic                     done_reg, done_next;
    logic [RETIRE_WIDTH-1:0]  retired_reg, retired_next;

    logic [THREADS_PER_BLOCK-1:0] lane_active;
    logic [THREADS_PER_BLOCK-1:0] lane_busy;
    logic [PC_WIDTH-1:0]          lane_pc [THREADS_PER_BLOCK];
    logic [IDX_W-1:0]             lead_idx;
    logic [PC_WIDTH-1:0]          lead_pc;
    logic                         start_go;

    // REQUESTING (01) and WAITING (10) are the only stalling encodings: bits differ.
    generate
        for (genvar gi = 0; gi < THREADS_PER_BLOCK; gi++) begin : g_lane
            assign lane_active[gi] = (TC_W'(gi) < thread_count);
            assign lane_busy[gi]   = lane_active[gi] &&
                                     (lsu_state[2*gi+1] ^ lsu_state[2*gi]);
            assign lane_pc[gi]     = next_pc[PC_WIDTH*gi +: PC_WIDTH];
        end
    endgenerate

    // Highest active lane supplies the shared PC; clamp out-of-range counts.
    always_comb begin
        lead_idx = '0;
        if (thread_count > TC_W'(THREADS_PER_BLOCK))
            lead_idx = IDX_W'(THREADS_PER_BLOCK - 1);
        else if (thread_count != '0)
            lead_idx = IDX_W'(thread_count - TC_W'(1));
    end
    assign lead_pc  = lane_pc[lead_idx];
    assign start_go = start && (thread_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            pc_reg      <= '0;
            done_reg    <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            done_reg    <= done_next;
            retired_reg <= retired_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        done_next    = done_reg;
        retired_next = retired_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_go) begin
                    state_next   = S_FETCH;
                    pc_next      = '0;
                    retired_next = '0;
                end else if (start) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                end
            end
            S_FETCH:   if (fetcher_state == FETCHER_FETCHED) state_next = S_DECODE;
            S_DECODE:  state_next = S_REQUEST;
            S_REQUEST: state_next = S_WAIT;
            S_WAIT:    if (lane_busy == '0) state_next = S_EXECUTE;
            S_EXECUTE: state_next = S_UPDATE;
            S_UPDATE: begin
                if (retired_reg != '1)
                    retired_next = retired_reg + 1'b1;
                if (decoded_ret) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                end else begin
                    state_next = S_FETCH;
                    pc_next    = lead_pc;
                end
            end
            S_DONE:    done_next = 1'b1;
            default:   state_next = S_IDLE;
        endcase
    end

    assign core_state = state_reg;
    assign current_pc = pc_reg;
    assign done       = done_reg;
    assign retired    = retired_reg;

`ifdef DIVERGE_CHECK_EN
    logic                         div_reg, div_next;
    logic [THREADS_PER_BLOCK-1:0] lane_diff;

    generate
        for (genvar gi = 0; gi < THREADS_PER_BLOCK; gi++) begin : g_div
            assign lane_diff[gi] = lane_active[gi] && (lane_pc[gi] != lead_pc);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) div_reg <= 1'b0;
        else       div_reg <= div_next;
    end

    // Sticky within a block; a fresh start clears it.
    always_comb begin
        div_next = div_reg;
        if (state_reg == S_IDLE && start_go)
            div_next = 1'b0;
        else if (state_reg == S_UPDATE && !decoded_ret && lane_diff != '0)
            div_next = 1'b1;
    end

    assign diverged = div_reg;
`else
    assign diverged = 1'b0;
`endif

endmodule

// File: tb/tb_core_scheduler.sv
// Self-checking bench for core_scheduler: directed vector table, hand sequences, random program vs model.
module tb_core_scheduler;
    localparam int T  = 4;
    localparam int PW = 8;
    localparam int RW = 4;
`ifdef DIVERGE_CHECK_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    thread_count;
    logic [2:0]    fetcher_state;
    logic [2*T-1:0] lsu_state;
    logic          decoded_ret;
    logic [PW*T-1:0] next_pc;
    logic [2:0]    core_state;
    logic [PW-1:0] current_pc;
    logic          done;
    logic [RW-1:0] retired;
    logic          diverged;

    core_scheduler #(.THREADS_PER_BLOCK(T), .PC_WIDTH(PW), .RETIRE_WIDTH(RW)) dut (
        .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
        .fetcher_state(fetcher_state), .lsu_state(lsu_state), .decoded_ret(decoded_ret),
        .next_pc(next_pc), .core_state(core_state), .current_pc(current_pc),
        .done(done), .retired(retired), .diverged(diverged)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int busy [4];
    logic [7:0] npc [4];

    typedef struct {
        bit             nb;    // reset and start a new block before this entry
        int             tc;
        int             fd;
        logic [3:0][3:0] b;
        logic [3:0][7:0] p;
        bit             ret;
        int             ew;
        logic [7:0]     epc;
        int             er;
        bit             ediv;  // expected diverged when the check is built
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural LSUs: inactive lanes sit at WAITING, active lanes stall busy[i] WAIT cycles.
    function automatic logic [7:0] lsu_drive(input int tc, input int in_wait, input int w);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] s;
            if (i >= tc)                s = 2'b10;
            else if (in_wait == 0)      s = 2'b00;
            else if (busy[i] == 0)      s = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
            else if (w < busy[i])       s = (w == 0) ? 2'b01 : 2'b10;
            else                        s = 2'b11;
            v[2*i +: 2] = s;
        end
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        step();
        reset = 1'b0;
        check("reset state", core_state, 3'b000);
    endtask

    task automatic do_start(input int tc);
        check("idle before start", core_state, 3'b000);
        start = 1'b1;
        thread_count = 3'(tc);
        step();
        start = 1'b0;
        check("start state", core_state, (tc == 0) ? 3'b111 : 3'b001);
        check("start pc", current_pc, 0);
        check("start retired", retired, 0);
        check("start done", done, (tc == 0) ? 1 : 0);
        check("start diverged", diverged, 0);
    endtask

    task automatic run_instr(input string tag, input int tc, input int fd, input bit ret,
                             input int exp_wait, input logic [7:0] exp_pc,
                             input int exp_ret, input bit exp_div);
        int n;
        int wn;
        thread_count = 3'(tc);
        check({tag, " in FETCH"}, core_state, 3'b001);
        n = 0;
        while (core_state == 3'b001 && n < 100) begin
            fetcher_state = (n >= fd) ? 3'b010 : 3'b001;
            lsu_state = lsu_drive(tc, 0, 0);
            step();
            n++;
        end
        fetcher_state = 3'b000;
        check({tag, " fetch cycles"}, n, fd + 1);
        check({tag, " DECODE"}, core_state, 3'b010);
        decoded_ret = ret;
        for (int i = 0; i < 4; i++) next_pc[8*i +: 8] = npc[i];
        step();
        check({tag, " REQUEST"}, core_state, 3'b011);
        step();
        check({tag, " WAIT"}, core_state, 3'b100);
        wn = 0;
        while (core_state == 3'b100 && wn < 100) begin
            lsu_state = lsu_drive(tc, 1, wn);
            step();
            wn++;
        end
        lsu_state = lsu_drive(tc, 0, 0);
        check({tag, " wait cycles"}, wn, exp_wait);
        check({tag, " EXECUTE"}, core_state, 3'b101);
        step();
        check({tag, " UPDATE"}, core_state, 3'b110);
        step();
        check({tag, " next state"}, core_state, ret ? 3'b111 : 3'b001);
        check({tag, " pc"}, current_pc, exp_pc);
        check({tag, " retired"}, retired, exp_ret);
        check({tag, " done"}, done, ret ? 1 : 0);
        check({tag, " diverged"}, diverged, DIV_ON ? exp_div : 1'b0);
        $display("instr %s: tc=%0d fetch=%0d wait=%0d pc=%0d retired=%0d done=%0b diverged=%0b",
                 tag, tc, n, wn, current_pc, retired, done, diverged);
    endtask

    task automatic hold_done(input logic [7:0] exp_pc, input int exp_ret);
        for (int k = 0; k < 4; k++) begin
            start = k[0];
            step();
            check("done hold state", core_state, 3'b111);
            check("done hold flag", done, 1);
            check("done hold pc", current_pc, exp_pc);
            check("done hold retired", retired, exp_ret);
        end
        start = 1'b0;
    endtask

    initial begin
        int m_pc;
        int m_ret;
        bit m_div;
        int tc, fd, mb, sel, n;
        bit rt;

        reset = 1'b1; start = 1'b0; thread_count = 3'd4; fetcher_state = 3'b000;
        lsu_state = '0; decoded_ret = 1'b0; next_pc = '0;
        step();
        check("reset core_state", core_state, 3'b000);
        check("reset pc", current_pc, 0);
        check("reset done", done, 0);
        check("reset retired", retired, 0);
        check("reset diverged", diverged, 0);
        reset = 1'b0;
        step();
        check("idle without start", core_state, 3'b000);

        tbl[0] = '{nb:1, tc:4, fd:0, b:16'h0000, p:{8'd1, 8'd1, 8'd1, 8'd1},
                   ret:0, ew:1, epc:8'd1, er:1, ediv:0};
        tbl[1] = '{nb:0, tc:4, fd:2, b:{4'd0, 4'd4, 4'd0, 4'd0}, p:{8'd2, 8'd2, 8'd2, 8'd2},
                   ret:0, ew:5, epc:8'd2, er:2, ediv:0};
        tbl[2] = '{nb:0, tc:4, fd:1, b:16'h0000, p:{8'd9, 8'd9, 8'd9, 8'd9},
                   ret:1, ew:1, epc:8'd2, er:3, ediv:0};
        tbl[3] = '{nb:1, tc:2, fd:0, b:16'h0000, p:{8'd99, 8'd0, 8'd4, 8'd4},
                   ret:0, ew:1, epc:8'd4, er:1, ediv:0};
        tbl[4] = '{nb:0, tc:4, fd:0, b:16'h0000, p:{8'd5, 8'd5, 8'd7, 8'd5},
                   ret:0, ew:1, epc:8'd5, er:2, ediv:1};
        tbl[5] = '{nb:0, tc:4, fd:3, b:{4'd2, 4'd0, 4'd3, 4'd1}, p:{8'd6, 8'd6, 8'd6, 8'd6},
                   ret:0, ew:4, epc:8'd6, er:3, ediv:1};
        tbl[6] = '{nb:0, tc:3, fd:1, b:{4'd7, 4'd0, 4'd0, 4'd2}, p:{8'd1, 8'd200, 8'd200, 8'd200},
                   ret:0, ew:3, epc:8'd200, er:4, ediv:1};

        for (int v = 0; v < 7; v++) begin
            if (tbl[v].nb) begin
                do_reset();
                do_start(tbl[v].tc);
            end
            for (int i = 0; i < 4; i++) begin
                busy[i] = int'(tbl[v].b[i]);
                npc[i]  = tbl[v].p[i];
            end
            run_instr($sformatf("vec%0d", v), tbl[v].tc, tbl[v].fd, tbl[v].ret,
                      tbl[v].ew, tbl[v].epc, tbl[v].er, tbl[v].ediv);
            if (tbl[v].ret) hold_done(tbl[v].epc, tbl[v].er);
        end

        // Reset while parked in WAIT with every lane still outstanding.
        thread_count = 3'd4;
        fetcher_state = 3'b010;
        n = 0;
        while (core_state != 3'b100 && n < 20) begin
            step();
            n++;
        end
        fetcher_state = 3'b000;
        lsu_state = 8'b1010_1010;
        check("reach WAIT", core_state, 3'b100);
        step();
        check("stall in WAIT", core_state, 3'b100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        lsu_state = '0;
        check("mid-wait reset state", core_state, 3'b000);
        check("mid-wait reset pc", current_pc, 0);
        check("mid-wait reset done", done, 0);
        check("mid-wait reset retired", retired, 0);
        check("mid-wait reset diverged", diverged, 0);

        do_start(0);
        hold_done(8'd0, 0);

        // Random program against a transaction-level model.
        do_reset();
        tc = $urandom_range(1, 4);
        do_start(tc);
        m_pc = 0; m_ret = 0; m_div = 0;
        for (int k = 0; k < 60; k++) begin
            tc = $urandom_range(1, 4);
            fd = $urandom_range(0, 3);
            rt = (k >= 20) && ($urandom_range(0, 9) == 0);
            npc[0] = 8'($urandom_range(0, 255));
            for (int i = 1; i < 4; i++)
                npc[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : npc[0];
            mb = 0;
            for (int i = 0; i < 4; i++) begin
                busy[i] = $urandom_range(0, 3);
                if (i < tc && busy[i] > mb) mb = busy[i];
            end
            sel = tc - 1;
            if (!rt) begin
                for (int i = 0; i < tc; i++)
                    if (npc[i] != npc[sel]) m_div = 1'b1;
                m_pc = npc[sel];
            end
            m_ret = (m_ret + 1 > (1 << RW) - 1) ? (1 << RW) - 1 : m_ret + 1;
            run_instr($sformatf("rnd%0d", k), tc, fd, rt, 1 + mb, 8'(m_pc), m_ret, m_div);
            if (rt) begin
                do_reset();
                tc = $urandom_range(1, 4);
                do_start(tc);
                m_pc = 0; m_ret = 0; m_div = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
